// File: rtl/tank_move_ctrl_pkg.sv
// tank_move_ctrl_pkg
// Shared types and constants for the tank movement controller:
//   dir_e     - direction encoding, also the encoding of the facing output
//   state_e   - movement FSM state encoding
//   SCREEN_W, SCREEN_H, TANK_SIZE - playfield geometry in pixels
//   pick_dir  - button priority encoder (up > down > left > right)
//   bound_ok  - screen-edge test for a full step in a given direction
package tank_move_ctrl_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_STEP   = 2'b10,
    ST_WAIT   = 2'b11
  } state_e;

  localparam logic [10:0] SCREEN_W  = 11'd640;
  localparam logic [10:0] SCREEN_H  = 11'd480;
  localparam logic [10:0] TANK_SIZE = 11'd32;

  function automatic dir_e pick_dir(input logic up, input logic down,
                                    input logic left);
    dir_e d;
    if (up)        d = UP;
    else if (down) d = DOWN;
    else if (left) d = LEFT;
    else           d = RIGHT;
    return d;
  endfunction

  // Done at 11 bits so ver+32+step cannot wrap near the bottom/right edge.
  // A step either fits entirely or is refused; there is no partial clamp.
  function automatic logic bound_ok(input dir_e d, input logic [9:0] ver,
                                    input logic [9:0] hor, input logic [9:0] step);
    logic [10:0] v;
    logic [10:0] h;
    logic [10:0] s;
    logic        ok;
    v = {1'b0, ver};
    h = {1'b0, hor};
    s = {1'b0, step};
    ok = 1'b0;
    case (d)
      UP:      ok = (v >= s);
      DOWN:    ok = ((v + TANK_SIZE + s) <= SCREEN_H);
      LEFT:    ok = (h >= s);
      RIGHT:   ok = ((h + TANK_SIZE + s) <= SCREEN_W);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tank_move_ctrl_if.sv
// tank_move_ctrl_if
// Bundles the controller's request/response signals.
//   btn_*          - debounced level move requests (active-high)
//   tank_*_valid   - collision-checker verdict for the current position
//   position_ver   - top edge of the 32x32 tank (feeds the collision checker)
//   position_hor   - left edge of the tank
//   facing         - last requested direction (00 up, 01 down, 10 left, 11 right)
//   moving         - one-cycle pulse after each committed step
// master: the movement controller; slave: buttons/checker/renderer side.
interface tank_move_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       tank_up_valid;
  logic       tank_down_valid;
  logic       tank_left_valid;
  logic       tank_right_valid;
  logic [9:0] position_ver;
  logic [9:0] position_hor;
  logic [1:0] facing;
  logic       moving;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right,
    input  tank_up_valid, tank_down_valid, tank_left_valid, tank_right_valid,
    output position_ver, position_hor, facing, moving
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right,
    output tank_up_valid, tank_down_valid, tank_left_valid, tank_right_valid,
    input  position_ver, position_hor, facing, moving
  );
endinterface

// File: rtl/tank_move_ctrl_move_timer.sv
// move_timer
// Step pacing counter. Counts 0..MOVE_PERIOD-1 while enabled.
//   clk, rst_n - clock, async active-low reset
//   clear      - synchronous return to 0 (has priority over enable)
//   enable     - advance by one per cycle
//   tc         - high while enabled and at the last count
module move_timer #(
  parameter int MOVE_PERIOD = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int TW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + TW'(1);
  end

  assign tc = enable && (count == TW'(MOVE_PERIOD - 1));

endmodule

// File: rtl/tank_move_ctrl.sv
// tank_move_ctrl
// Moves a 32x32 tank around a 640x480 screen one STEP at a time while a
// direction button is held, gated by the collision checker and screen edges.
//   clk   - system clock, rising edge
//   rst_n - async active-low reset
//   bus   - tank_move_ctrl_if.master (buttons, checker verdicts, position,
//           facing, moving)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a button; latches direction and facing
// ST_SETTLE | one cycle so the checker evaluates a stable position
// ST_STEP   | commit the move if permitted; restart the pacing timer
// ST_WAIT   | MOVE_PERIOD cycles; then repeat if still held, else idle
module tank_move_ctrl
  import tank_move_ctrl_pkg::*;
#(
  parameter logic [9:0] INIT_VER    = 10'd400,
  parameter logic [9:0] INIT_HOR    = 10'd100,
  parameter logic [9:0] STEP        = 10'd1,
  parameter int         MOVE_PERIOD = 250000
) (
  input logic            clk,
  input logic            rst_n,
  tank_move_ctrl_if.master bus
);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  dir_e       facing_q, facing_d;
  logic [9:0] ver_q, ver_d;
  logic [9:0] hor_q, hor_d;
  logic       moving_q, moving_d;
  logic       timer_clear, timer_en, timer_tc;
  logic [3:0] valid_vec;
  logic [3:0] btn_vec;

  // Indexed by dir_e encoding.
  assign valid_vec = {bus.tank_right_valid, bus.tank_left_valid,
                      bus.tank_down_valid,  bus.tank_up_valid};
  assign btn_vec   = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  move_timer #(.MOVE_PERIOD(MOVE_PERIOD)) u_move_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= UP;
      facing_q <= UP;
      ver_q    <= INIT_VER;
      hor_q    <= INIT_HOR;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      facing_q <= facing_d;
      ver_q    <= ver_d;
      hor_q    <= hor_d;
      moving_q <= moving_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    facing_d    = facing_q;
    ver_d       = ver_q;
    hor_d       = hor_q;
    moving_d    = 1'b0;
    timer_clear = 1'b1;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|btn_vec) begin
          dir_d    = pick_dir(bus.btn_up, bus.btn_down, bus.btn_left);
          facing_d = dir_d;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: state_d = ST_STEP;
      ST_STEP: begin
        state_d = ST_WAIT;
        if (valid_vec[dir_q] && bound_ok(dir_q, ver_q, hor_q, STEP)) begin
          moving_d = 1'b1;
          case (dir_q)
            UP:      ver_d = ver_q - STEP;
            DOWN:    ver_d = ver_q + STEP;
            LEFT:    hor_d = hor_q - STEP;
            default: hor_d = hor_q + STEP;
          endcase
        end
      end
      ST_WAIT: begin
        timer_clear = 1'b0;
        timer_en    = 1'b1;
        // Only the latched direction's button keeps the repeat going;
        // anything else must come back through IDLE.
        if (timer_tc) state_d = btn_vec[dir_q] ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.position_ver = ver_q;
  assign bus.position_hor = hor_q;
  assign bus.facing       = facing_q;
  assign bus.moving       = moving_q;

endmodule
